// File: rtl/vuvmu_ctrl_lrq_arb_pkg.sv
// ---------------------------------------------------------------------------
// vuvmu_ctrl_lrq_arb_pkg
// Shared VMU control configuration for the load-request-queue arbiter:
// arbiter state encodings, requester identifiers, default burst limit and
// the request field widths of the shared LRQ enqueue port.
// ---------------------------------------------------------------------------
package vuvmu_ctrl_lrq_arb_pkg;

  // Arbiter states: idle, or the LRQ port is owned by one requester.
  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_GRANT_VEC = 2'd1,
    ARB_GRANT_UT  = 2'd2
  } arb_state_e;

  // Requester identifiers, as stored in the last_grant bit.
  localparam logic REQ_VEC = 1'b0;
  localparam logic REQ_UT  = 1'b1;

  // Default number of accepted beats before a contended grant is handed over.
  localparam int unsigned DEFAULT_MAX_BURST = 16;

  // LRQ request field widths.
  localparam int unsigned LRQ_ADDR_W = 30;
  localparam int unsigned LRQ_TAG_W  = 12;

  // Grant state that serves the given requester.
  function automatic arb_state_e grant_state(input logic req_id);
    arb_state_e st;
    if (req_id == REQ_UT) begin
      st = ARB_GRANT_UT;
    end else begin
      st = ARB_GRANT_VEC;
    end
    return st;
  endfunction

endpackage

// File: rtl/vuvmu_ctrl_lrq_arb.sv
// ---------------------------------------------------------------------------
// vuvmu_ctrl_lrq_arb
// Arbitrates the single load-request-queue enqueue port between the vector
// issue unit (VEC) and the UT issue unit (UT). A requester is granted for as
// long as its issue_busy is high; when both are busy the grant alternates
// after MAX_BURST accepted beats. Requests pass straight through (no
// buffering): the granted requester's addr/tag/val drive the LRQ port and
// its rdy is the LRQ rdy, with zero latency.
//
// Ports
//   clk, reset                     sole clock, synchronous active-high reset
//   vec_lrq_enq_{addr,tag}_bits/val  VEC load request in
//   vec_lrq_enq_rdy                VEC ready out (only while VEC is granted)
//   vec_issue_busy                 VEC issue command in progress
//   ut_lrq_enq_*/ut_issue_busy     same for the UT requester
//   lrq_enq_{addr,tag}_bits/val    shared LRQ request out
//   lrq_enq_rdy                    shared LRQ ready in
//   arb_busy                       grant active or any requester busy
// ---------------------------------------------------------------------------
module vuvmu_ctrl_lrq_arb
  import vuvmu_ctrl_lrq_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = DEFAULT_MAX_BURST
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [LRQ_ADDR_W-1:0] vec_lrq_enq_addr_bits,
  input  logic [LRQ_TAG_W-1:0]  vec_lrq_enq_tag_bits,
  input  logic                  vec_lrq_enq_val,
  output logic                  vec_lrq_enq_rdy,
  input  logic                  vec_issue_busy,
  input  logic [LRQ_ADDR_W-1:0] ut_lrq_enq_addr_bits,
  input  logic [LRQ_TAG_W-1:0]  ut_lrq_enq_tag_bits,
  input  logic                  ut_lrq_enq_val,
  output logic                  ut_lrq_enq_rdy,
  input  logic                  ut_issue_busy,
  output logic [LRQ_ADDR_W-1:0] lrq_enq_addr_bits,
  output logic [LRQ_TAG_W-1:0]  lrq_enq_tag_bits,
  output logic                  lrq_enq_val,
  input  logic                  lrq_enq_rdy,
  output logic                  arb_busy
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

  arb_state_e       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

  logic transfer_s;
  logic burst_last_s;

  // Output mux: route the granted requester to the LRQ port. Grants are
  // suppressed while reset is high so no beat can be accepted in that cycle.
  always_comb begin
    lrq_enq_addr_bits = vec_lrq_enq_addr_bits;
    lrq_enq_tag_bits  = vec_lrq_enq_tag_bits;
    lrq_enq_val       = 1'b0;
    vec_lrq_enq_rdy   = 1'b0;
    ut_lrq_enq_rdy    = 1'b0;
    if (reset) begin
      lrq_enq_val = 1'b0;
    end else begin
      case (state_q)
        ARB_GRANT_VEC: begin
          lrq_enq_val     = vec_lrq_enq_val;
          vec_lrq_enq_rdy = lrq_enq_rdy;
        end
        ARB_GRANT_UT: begin
          lrq_enq_addr_bits = ut_lrq_enq_addr_bits;
          lrq_enq_tag_bits  = ut_lrq_enq_tag_bits;
          lrq_enq_val       = ut_lrq_enq_val;
          ut_lrq_enq_rdy    = lrq_enq_rdy;
        end
        default: begin
          lrq_enq_val = 1'b0;
        end
      endcase
    end
  end

  assign transfer_s   = lrq_enq_val & lrq_enq_rdy;
  assign burst_last_s = (burst_cnt_q == BURST_LAST);
  assign arb_busy     = ((state_q != ARB_IDLE) & ~reset) | vec_issue_busy | ut_issue_busy;

  // Next-state, last-grant and burst counter logic.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    burst_cnt_d  = burst_cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (vec_issue_busy && ut_issue_busy) begin
          // Tie: serve whoever was not served last.
          state_d = grant_state(~last_grant_q);
        end else if (vec_issue_busy) begin
          state_d = ARB_GRANT_VEC;
        end else if (ut_issue_busy) begin
          state_d = ARB_GRANT_UT;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_GRANT_VEC: begin
        // Preemption only fires on an accepted beat, so the last beat of the
        // burst is never lost.
        if (transfer_s && burst_last_s && ut_issue_busy) begin
          state_d = ARB_GRANT_UT;
        end else if (!vec_issue_busy) begin
          state_d = ut_issue_busy ? ARB_GRANT_UT : ARB_IDLE;
        end else begin
          state_d = ARB_GRANT_VEC;
        end
        if (state_d != ARB_GRANT_VEC) begin
          last_grant_d = REQ_VEC;
        end else begin
          last_grant_d = last_grant_q;
        end
      end
      ARB_GRANT_UT: begin
        if (transfer_s && burst_last_s && vec_issue_busy) begin
          state_d = ARB_GRANT_VEC;
        end else if (!ut_issue_busy) begin
          state_d = vec_issue_busy ? ARB_GRANT_VEC : ARB_IDLE;
        end else begin
          state_d = ARB_GRANT_UT;
        end
        if (state_d != ARB_GRANT_UT) begin
          last_grant_d = REQ_UT;
        end else begin
          last_grant_d = last_grant_q;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase

    // The counter measures beats within one grant tenure.
    if (state_d != state_q) begin
      burst_cnt_d = {CNT_W{1'b0}};
    end else if (transfer_s) begin
      burst_cnt_d = burst_cnt_q + CNT_W'(1);
    end else begin
      burst_cnt_d = burst_cnt_q;
    end
  end

  // State, last-grant and counter registers. last_grant resets to UT so
  // VEC wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= REQ_UT;
      burst_cnt_q  <= {CNT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

endmodule
